mult_share_arbiter: RTL and testbench

- Round-robin arbiter/sequencer that shares one cordic_mult instance between NREQ requesters, e.g. rule multipliers of several fuzzy controllers or channels.
- Latches the winning requester's operands and issues a one-cycle start to the multiplier.
- Waits for the multiplier's rdy, then returns the product to the owning requester with a done pulse.
- Sits between the requester FSMs and the single multiplier instance.

---
 rtl/fuzzy_ctrl_pkg.sv | 11 +
 rtl/rr_pick.sv | 26 ++
 rtl/mult_share_arbiter.sv | 140 ++++++++++++++
 tb/tb_mult_share_arbiter.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fuzzy_ctrl_pkg.sv
// fuzzy_ctrl_pkg: state encodings and default sizing shared by the multiplier-sharing arbiter.
package fuzzy_ctrl_pkg;
    typedef enum logic [2:0] {
        ST_IDLE  = 3'b001,
        ST_ISSUE = 3'b010,
        ST_WAIT  = 3'b100
    } state_t;
    localparam int N_DEF       = 16;
    localparam int NREQ_DEF    = 4;
    localparam int TMO_CYC_DEF = 64;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin picker; returns the first set req bit searching cyclically from ptr+1.
module rr_pick #(
    parameter int  NREQ = 4,
    localparam int PW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [PW-1:0]   sel,
    output logic            any_req
);
    logic [2*NREQ-1:0] dbl;
    logic [NREQ-1:0]   rot;
    logic [PW:0]       start;
    logic [PW:0]       sum;
    logic [PW-1:0]     off;
    always_comb begin
        start = {1'b0, ptr} + (PW+1)'(1);
        dbl   = {req, req};
        rot   = NREQ'(dbl >> start);
        off   = '0;
        for (int i = NREQ - 1; i >= 0; i--) off = rot[i] ? PW'(i) : off;
        sum     = start + {1'b0, off};
        sel     = PW'(sum >= (PW+1)'(NREQ) ? sum - (PW+1)'(NREQ) : sum);
        any_req = |req;
    end
endmodule

// File: rtl/mult_share_arbiter.sv
// mult_share_arbiter: round-robin sharing of one multiplier among NREQ requesters.
// Define MULT_SHARE_TIMEOUT_EN to abort a multiply whose rdy is not seen within TMO_CYC wait cycles.
module mult_share_arbiter
    import fuzzy_ctrl_pkg::*;
#(
    parameter int  N       = N_DEF,
    parameter int  NREQ    = NREQ_DEF,
    parameter int  TMO_CYC = TMO_CYC_DEF,
    localparam int PW      = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*N-1:0] a_bus,
    input  logic [NREQ*N-1:0] b_bus,
    output logic [NREQ-1:0]   ack,
    output logic [NREQ-1:0]   done,
    output logic [N-1:0]      c,
    output logic              busy,
    output logic              err,
    output logic              m_start,
    output logic [N-1:0]      m_a,
    output logic [N-1:0]      m_b,
    input  logic [N-1:0]      m_c,
    input  logic              m_rdy
);
    state_t          state_q, state_d;
    logic [PW-1:0]   owner_q, owner_d, ptr_q, ptr_d, sel;
    logic [NREQ-1:0] ack_q, ack_d, done_q, done_d;
    logic [N-1:0]    c_q, c_d, m_a_q, m_a_d, m_b_q, m_b_d, sel_a, sel_b;
    logic            busy_q, busy_d, m_start_q, m_start_d, any_req, tmo;

    rr_pick #(.NREQ(NREQ)) u_pick (
        .req    (req),
        .ptr    (ptr_q),
        .sel    (sel),
        .any_req(any_req)
    );

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int k = 0; k < NREQ; k++) begin
            sel_a = (sel == PW'(k)) ? a_bus[k*N +: N] : sel_a;
            sel_b = (sel == PW'(k)) ? b_bus[k*N +: N] : sel_b;
        end
    end

`ifdef MULT_SHARE_TIMEOUT_EN
    localparam int CW = $clog2(TMO_CYC + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
    assign tmo = (state_q == ST_WAIT) && !m_rdy && (cnt_q == CW'(TMO_CYC - 1));
    always_comb begin
        cnt_d = (state_q == ST_WAIT) ? cnt_q + CW'(1) : '0;
        err_d = err_q | tmo;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end
    assign err = err_q;
`else
    assign tmo = 1'b0;
    assign err = TMO_CYC < 0;
`endif

    // rdy seen in ST_ISSUE may belong to the previous operation, so only ST_WAIT completes
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        ptr_d     = ptr_q;
        ack_d     = '0;
        done_d    = '0;
        c_d       = c_q;
        busy_d    = busy_q;
        m_start_d = 1'b0;
        m_a_d     = m_a_q;
        m_b_d     = m_b_q;
        case (state_q)
            ST_IDLE: if (any_req) begin
                state_d   = ST_ISSUE;
                owner_d   = sel;
                ack_d     = NREQ'(1) << sel;
                m_start_d = 1'b1;
                busy_d    = 1'b1;
                m_a_d     = sel_a;
                m_b_d     = sel_b;
            end
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT: if (m_rdy || tmo) begin
                state_d = ST_IDLE;
                c_d     = m_rdy ? m_c : '0;
                done_d  = NREQ'(1) << owner_q;
                ptr_d   = owner_q;
                busy_d  = 1'b0;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            owner_q   <= '0;
            ptr_q     <= PW'(NREQ - 1);
            ack_q     <= '0;
            done_q    <= '0;
            c_q       <= '0;
            busy_q    <= 1'b0;
            m_start_q <= 1'b0;
            m_a_q     <= '0;
            m_b_q     <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            ptr_q     <= ptr_d;
            ack_q     <= ack_d;
            done_q    <= done_d;
            c_q       <= c_d;
            busy_q    <= busy_d;
            m_start_q <= m_start_d;
            m_a_q     <= m_a_d;
            m_b_q     <= m_b_d;
        end
    end

    assign ack     = ack_q;
    assign done    = done_q;
    assign c       = c_q;
    assign busy    = busy_q;
    assign m_start = m_start_q;
    assign m_a     = m_a_q;
    assign m_b     = m_b_q;
endmodule

// File: tb/tb_mult_share_arbiter.sv
// tb_mult_share_arbiter: randomized self-checking bench with a behavioural round-robin model
// and a Q1.15 multiplier model with configurable latency, stale rdy, hang and always-ready modes.
module tb_mult_share_arbiter;
    localparam int N    = 16;
    localparam int NREQ = 4;
    localparam int TMO  = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NREQ-1:0]   req = '0;
    logic [N-1:0]      a_op [NREQ];
    logic [N-1:0]      b_op [NREQ];
    logic [NREQ*N-1:0] a_bus, b_bus;
    logic [NREQ-1:0]   ack, done;
    logic [N-1:0]      c, m_a, m_b;
    logic [N-1:0]      m_c = '0;
    logic              m_rdy = 1'b0;
    logic              busy, err, m_start;
    int total = 0;
    int bad = 0;
    int mptr = NREQ - 1;
    bit stale = 0, hang = 0, keep = 0, rand_lat = 0;
    int lat = 4, mcnt = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NREQ; g++) begin : g_pack
        assign a_bus[g*N +: N] = a_op[g];
        assign b_bus[g*N +: N] = b_op[g];
    end

    mult_share_arbiter #(.N(N), .NREQ(NREQ), .TMO_CYC(TMO)) dut (
        .clk(clk), .rst(rst), .req(req), .a_bus(a_bus), .b_bus(b_bus),
        .ack(ack), .done(done), .c(c), .busy(busy), .err(err),
        .m_start(m_start), .m_a(m_a), .m_b(m_b), .m_c(m_c), .m_rdy(m_rdy)
    );

    function automatic logic [N-1:0] prod(input logic [N-1:0] a, input logic [N-1:0] b);
        logic signed [2*N-1:0] p;
        p = $signed(a) * $signed(b);
        return p[2*N-2 -: N];
    endfunction

    function automatic int rr_next(input logic [NREQ-1:0] r, input int p);
        for (int i = 1; i <= NREQ; i++) if (r[(p + i) % NREQ]) return (p + i) % NREQ;
        return -1;
    endfunction

    // multiplier model: rdy rises lat cycles after start and stays high until the next start
    always @(negedge clk) begin
        if (!rst) begin
            m_rdy = 1'b0;
            mcnt  = 0;
        end else if (m_start) begin
            mcnt  = rand_lat ? int'($urandom_range(1, 12)) : lat;
            m_rdy = stale | keep;
            m_c   = keep ? prod(m_a, m_b) : 16'hDEAD;
        end else if (keep) begin
            m_rdy = 1'b1;
        end else if (mcnt > 0 && !hang) begin
            mcnt--;
            m_rdy = (mcnt == 0);
            if (mcnt == 0) m_c = prod(m_a, m_b);
        end
    end

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b0; req = '0; stale = 0; hang = 0; keep = 0; rand_lat = 0; lat = 4;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        mptr = NREQ - 1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #2 rst = 1'b0;
        #1;
        total++;
        if ({ack, done, c, busy, err, m_start, m_a, m_b} !== '0) begin
            bad++; $display("FAIL reset_async: outputs=%h required 0", {ack, done, c, busy, err, m_start, m_a, m_b});
        end
        req = 4'b1111;
        repeat (3) @(negedge clk);
        total++;
        if ({ack, done, c, busy, err, m_start, m_a, m_b} !== '0) begin
            bad++; $display("FAIL reset_hold: outputs=%h required 0", {ack, done, c, busy, err, m_start, m_a, m_b});
        end
        req = '0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if (busy !== 1'b0 || ack !== '0 || err !== 1'b0) begin
            bad++; $display("FAIL reset_idle: busy=%b ack=%b err=%b required 0 0 0", busy, ack, err);
        end
    endtask

    task automatic test_single();
        int n;
        apply_reset();
        lat = 10;
        a_op[0] = 16'h4000; b_op[0] = 16'h4000;
        req = 4'b0001;
        @(negedge clk);
        total++;
        if (ack !== 4'b0001 || m_start !== 1'b1 || busy !== 1'b1) begin
            bad++; $display("FAIL single_grant: ack=%b m_start=%b busy=%b required 0001 1 1", ack, m_start, busy);
        end
        total++;
        if (m_a !== 16'h4000 || m_b !== 16'h4000) begin
            bad++; $display("FAIL single_operands: m_a=%h m_b=%h required 4000 4000", m_a, m_b);
        end
        req = '0;
        @(negedge clk);
        total++;
        if (ack !== '0 || m_start !== 1'b0) begin
            bad++; $display("FAIL single_issue: ack=%b m_start=%b required 0000 0", ack, m_start);
        end
        n = 1;
        while (done === '0 && n < 40) begin @(negedge clk); n++; end
        total++;
        if (n != 11 || done !== 4'b0001 || c !== 16'h2000) begin
            bad++; $display("FAIL single_done: cycles=%0d done=%b c=%h required 11 0001 2000", n, done, c);
        end
        total++;
        if (busy !== 1'b0) begin
            bad++; $display("FAIL single_busy: busy=%b required 0", busy);
        end
        @(negedge clk);
        total++;
        if (done !== '0 || c !== 16'h2000) begin
            bad++; $display("FAIL single_hold: done=%b c=%h required 0000 2000", done, c);
        end
    endtask

    // mode 0: all four request at once; mode 1: requester 1 re-requests against 3; mode 2: random traffic
    task automatic test_arbitration(input int mode, input int grants);
        int owner = -1, exp, ng = 0, nd = 0, cyc = 0;
        int order[$];
        logic [N-1:0] exp_c = '0;
        apply_reset();
        rand_lat = (mode == 2);
        for (int k = 0; k < NREQ; k++) begin
            a_op[k] = N'(16'h1000 * (k + 1));
            b_op[k] = N'(16'h1000 * (k + 1));
        end
        req = (mode == 0) ? 4'b1111 : (mode == 1) ? 4'b0010 : 4'b0000;
        while (nd < grants && cyc < 4000) begin
            @(negedge clk);
            cyc++;
            if (ack !== '0) begin
                exp = rr_next(req, mptr);
                total++;
                if (exp < 0 || owner >= 0 || ack !== (NREQ'(1) << exp) || m_start !== 1'b1) begin
                    bad++; $display("FAIL arb%0d_grant%0d: ack=%b m_start=%b required ack=%b m_start=1", mode, ng, ack, m_start, NREQ'(1) << exp);
                end
                owner = (exp < 0) ? 0 : exp;
                total++;
                if (m_a !== a_op[owner] || m_b !== b_op[owner]) begin
                    bad++; $display("FAIL arb%0d_operands%0d: m_a=%h m_b=%h required %h %h", mode, ng, m_a, m_b, a_op[owner], b_op[owner]);
                end
                exp_c = prod(a_op[owner], b_op[owner]);
                order.push_back($clog2(ack));
                ng++;
                if (mode == 1 && ng == 1) req[3] = 1'b1;
                req[owner] = (mode == 2) ? ($urandom_range(0, 3) == 0) : 1'b0;
            end
            if (done !== '0) begin
                total++;
                if (owner < 0 || done !== (NREQ'(1) << owner) || c !== exp_c || busy !== 1'b0) begin
                    bad++; $display("FAIL arb%0d_done%0d: done=%b c=%h busy=%b required done=%b c=%h busy=0", mode, nd, done, c, busy, NREQ'(1) << owner, exp_c);
                end
                if (mode == 1 && owner == 1 && nd + 1 < grants) req[1] = 1'b1;
                mptr = (owner < 0) ? mptr : owner;
                owner = -1;
                nd++;
            end
            if (mode == 2) begin
                for (int k = 0; k < NREQ; k++) begin
                    if (!req[k] && $urandom_range(0, 3) == 0) req[k] = 1'b1;
                    else if (req[k] && $urandom_range(0, 15) == 0) req[k] = 1'b0;
                    a_op[k] = N'($urandom);
                    b_op[k] = N'($urandom);
                end
            end
        end
        total++;
        if (nd < grants) begin
            bad++; $display("FAIL arb%0d_progress: completions=%0d required %0d", mode, nd, grants);
        end
        if (mode == 0) begin
            total++;
            if (order.size() < 4 || order[0] != 0 || order[1] != 1 || order[2] != 2 || order[3] != 3) begin
                bad++; $display("FAIL arb0_order: got %p required 0 1 2 3", order);
            end
        end
        if (mode == 1) begin
            total++;
            if (order.size() < 3 || order[0] != 1 || order[1] != 3 || order[2] != 1) begin
                bad++; $display("FAIL arb1_fairness: got %p required 1 3 1", order);
            end
        end
    endtask

    task automatic test_stale_rdy();
        int n;
        apply_reset();
        stale = 1; lat = 5;
        a_op[2] = N'($urandom); b_op[2] = N'($urandom);
        req = 4'b0100;
        @(negedge clk);
        total++;
        if (ack !== 4'b0100) begin
            bad++; $display("FAIL stale_grant: ack=%b required 0100", ack);
        end
        req = '0;
        n = 0;
        while (done === '0 && n < 30) begin @(negedge clk); n++; end
        total++;
        if (n != 6 || done !== 4'b0100 || c !== prod(a_op[2], b_op[2])) begin
            bad++; $display("FAIL stale_done: cycles=%0d done=%b c=%h required 6 0100 %h", n, done, c, prod(a_op[2], b_op[2]));
        end
    endtask

    task automatic test_reset_mid_op();
        int n;
        apply_reset();
        lat = 10;
        a_op[0] = 16'h3000; b_op[0] = 16'h5000;
        req = 4'b0001;
        @(negedge clk);
        req = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        total++;
        if ({ack, done, c, busy, err, m_start, m_a, m_b} !== '0) begin
            bad++; $display("FAIL midreset_outputs: outputs=%h required 0", {ack, done, c, busy, err, m_start, m_a, m_b});
        end
        keep = 1;
        @(negedge clk);
        rst = 1'b1;
        mptr = NREQ - 1;
        n = 0;
        repeat (12) begin @(negedge clk); if (done !== '0 || busy !== 1'b0) n++; end
        total++;
        if (n != 0) begin
            bad++; $display("FAIL midreset_no_done: bad cycles=%0d required 0", n);
        end
        a_op[2] = 16'h4000; b_op[2] = 16'h2000;
        req = 4'b0100;
        @(negedge clk);
        total++;
        if (ack !== 4'b0100 || m_a !== 16'h4000 || m_b !== 16'h2000) begin
            bad++; $display("FAIL midreset_regrant: ack=%b m_a=%h m_b=%h required 0100 4000 2000", ack, m_a, m_b);
        end
        req = '0;
        n = 0;
        while (done === '0 && n < 10) begin @(negedge clk); n++; end
        total++;
        if (done !== 4'b0100 || c !== 16'h1000) begin
            bad++; $display("FAIL midreset_done: done=%b c=%h required 0100 1000", done, c);
        end
    endtask

`ifdef MULT_SHARE_TIMEOUT_EN
    task automatic test_timeout();
        int n;
        keep = 0; stale = 0; hang = 1; lat = 3;
        a_op[0] = 16'h1234; b_op[0] = 16'h4321;
        req = 4'b0001;
        @(negedge clk);
        total++;
        if (ack !== 4'b0001) begin
            bad++; $display("FAIL tmo_grant: ack=%b required 0001", ack);
        end
        req = '0;
        n = 0;
        while (done === '0 && n < 40) begin @(negedge clk); n++; end
        total++;
        if (n != TMO + 1 || done !== 4'b0001 || c !== '0 || err !== 1'b1 || busy !== 1'b0) begin
            bad++; $display("FAIL tmo_abort: cycles=%0d done=%b c=%h err=%b busy=%b required %0d 0001 0000 1 0", n, done, c, err, busy, TMO + 1);
        end
        hang = 0;
        a_op[1] = 16'h2000; b_op[1] = 16'h6000;
        req = 4'b0010;
        @(negedge clk);
        total++;
        if (ack !== 4'b0010) begin
            bad++; $display("FAIL tmo_regrant: ack=%b required 0010", ack);
        end
        req = '0;
        n = 0;
        while (done === '0 && n < 20) begin @(negedge clk); n++; end
        total++;
        if (done !== 4'b0010 || c !== prod(16'h2000, 16'h6000) || err !== 1'b1) begin
            bad++; $display("FAIL tmo_sticky: done=%b c=%h err=%b required 0010 %h 1", done, c, err, prod(16'h2000, 16'h6000));
        end
        apply_reset();
        total++;
        if (err !== 1'b0) begin
            bad++; $display("FAIL tmo_clear: err=%b required 0", err);
        end
    endtask
`else
    task automatic test_timeout();
        int n;
        keep = 0; stale = 0; hang = 1; lat = 4;
        a_op[1] = 16'h2000; b_op[1] = 16'h6000;
        req = 4'b0010;
        @(negedge clk);
        total++;
        if (ack !== 4'b0010) begin
            bad++; $display("FAIL nowd_grant: ack=%b required 0010", ack);
        end
        req = '0;
        n = 0;
        repeat (100) begin @(negedge clk); if (done !== '0 || busy !== 1'b1 || err !== 1'b0) n++; end
        total++;
        if (n != 0) begin
            bad++; $display("FAIL nowd_wait: bad cycles=%0d required 0", n);
        end
        hang = 0;
        n = 0;
        while (done === '0 && n < 20) begin @(negedge clk); n++; end
        total++;
        if (done !== 4'b0010 || c !== prod(16'h2000, 16'h6000)) begin
            bad++; $display("FAIL nowd_done: done=%b c=%h required 0010 %h", done, c, prod(16'h2000, 16'h6000));
        end
    endtask
`endif

    initial begin
        for (int k = 0; k < NREQ; k++) begin a_op[k] = '0; b_op[k] = '0; end
        test_reset();
        test_single();
        test_arbitration(0, 4);
        test_arbitration(1, 3);
        test_arbitration(2, 40);
        test_stale_rdy();
        test_reset_mid_op();
        test_timeout();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1);
    end
endmodule
